// File: rtl/vga_sync_ctrl.sv
// rtl/vga_sync_ctrl.sv - programmable VGA raster timing controller
// Pixel-rate divider, h/v raster counters and registered sync/blank/marker decode.
module vga_sync_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   CLK_DIV  = 4,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vga_en,
  output logic       pix_ce,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       de,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // 11-bit bounds so a 1024-wide active region still compares correctly
  localparam logic [10:0] H_BLANK_START = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_BLANK_START = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  w_div_nxt;
  logic              r_pix_ce;
  logic              w_pix_ce_nxt;
  logic [9:0]        r_hcnt;
  logic [9:0]        w_hcnt_nxt;
  logic [9:0]        r_vcnt;
  logic [9:0]        w_vcnt_nxt;
  logic              r_hsync;
  logic              w_hsync_nxt;
  logic              r_vsync;
  logic              w_vsync_nxt;
  logic              r_hblank;
  logic              w_hblank_nxt;
  logic              r_vblank;
  logic              w_vblank_nxt;
  logic              r_de;
  logic              w_de_nxt;
  logic              r_line_start;
  logic              w_line_start_nxt;
  logic              r_frame_start;
  logic              w_frame_start_nxt;
  logic              w_run_nxt;
  logic [10:0]       w_hx;
  logic [10:0]       w_vx;

  // Next-state and counter logic; defaults are the IDLE values
  always_comb begin
    w_state_nxt       = ST_IDLE;
    w_div_nxt         = '0;
    w_pix_ce_nxt      = 1'b0;
    w_hcnt_nxt        = '0;
    w_vcnt_nxt        = '0;
    w_line_start_nxt  = 1'b0;
    w_frame_start_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (vga_en) begin
          w_state_nxt       = ST_RUN;
          w_pix_ce_nxt      = (DIV_LAST == '0);
          w_line_start_nxt  = 1'b1;
          w_frame_start_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (vga_en) begin
          w_state_nxt  = ST_RUN;
          w_div_nxt    = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
          w_pix_ce_nxt = (w_div_nxt == DIV_LAST);
          w_hcnt_nxt   = r_hcnt;
          w_vcnt_nxt   = r_vcnt;
          if (r_pix_ce) begin
            if (r_hcnt == H_LAST) begin
              w_hcnt_nxt        = '0;
              w_vcnt_nxt        = (r_vcnt == V_LAST) ? '0 : r_vcnt + 10'd1;
              w_line_start_nxt  = 1'b1;
              w_frame_start_nxt = (r_vcnt == V_LAST);
            end else begin
              w_hcnt_nxt = r_hcnt + 10'd1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Decode the next counter values so each flag lands with the count it describes
  always_comb begin
    w_run_nxt    = (w_state_nxt == ST_RUN);
    w_hx         = {1'b0, w_hcnt_nxt};
    w_vx         = {1'b0, w_vcnt_nxt};
    w_hblank_nxt = !w_run_nxt || (w_hx >= H_BLANK_START);
    w_vblank_nxt = !w_run_nxt || (w_vx >= V_BLANK_START);
    w_de_nxt     = !w_hblank_nxt && !w_vblank_nxt;
    w_hsync_nxt  = (w_run_nxt && (w_hx >= H_SYNC_START) && (w_hx < H_SYNC_END))
                   ? HS_POL : ~HS_POL;
    w_vsync_nxt  = (w_run_nxt && (w_vx >= V_SYNC_START) && (w_vx < V_SYNC_END))
                   ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_div         <= '0;
      r_pix_ce      <= 1'b0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_hblank      <= 1'b1;
      r_vblank      <= 1'b1;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_div         <= w_div_nxt;
      r_pix_ce      <= w_pix_ce_nxt;
      r_hcnt        <= w_hcnt_nxt;
      r_vcnt        <= w_vcnt_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_hblank      <= w_hblank_nxt;
      r_vblank      <= w_vblank_nxt;
      r_de          <= w_de_nxt;
      r_line_start  <= w_line_start_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign pix_ce      = r_pix_ce;
  assign hcnt        = r_hcnt;
  assign vcnt        = r_vcnt;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign hblank      = r_hblank;
  assign vblank      = r_vblank;
  assign de          = r_de;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
